// File: rtl/trace_buffer.sv
// Retire-trace capture buffer: packs up to NRET commit events per cycle into an
// in-order FIFO and replays them one per cycle on a valid/ready stream.
module trace_buffer #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SEQ_W = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     flush,
    input  logic [NRET-1:0]          in_valid,
    input  logic [NRET*XLEN-1:0]     in_pc,
    input  logic [NRET*32-1:0]       in_inst,
    input  logic [NRET-1:0]          in_rdv,
    input  logic [NRET*5-1:0]        in_rd,
    input  logic [NRET*XLEN-1:0]     in_rd_data,
    input  logic [NRET-1:0]          in_pcv,
    input  logic [NRET*XLEN-1:0]     in_pc_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_valid_i,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_rdv,
    output logic [4:0]               out_rd,
    output logic [XLEN-1:0]          out_rd_data,
    output logic                     out_pcv,
    output logic [XLEN-1:0]          out_pc_x,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned NCNT_W = 3;
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef struct packed {
        logic             valid_i;
        logic [XLEN-1:0]  pc;
        logic [31:0]      inst;
        logic             rdv;
        logic [4:0]       rd;
        logic [XLEN-1:0]  rd_data;
        logic             pcv;
        logic [XLEN-1:0]  pc_x;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    entry_t             ent [NRET];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [SEQ_W-1:0]   seq;

    logic [NRET-1:0]    ev;
    logic [NCNT_W-1:0]  off [NRET];
    logic [NCNT_W-1:0]  n_ev;
    logic [NCNT_W-1:0]  n_ret;
    logic [NCNT_W-1:0]  n_push;
    logic [LVL_W-1:0]   free;
    logic               drop;
    logic               accept;
    logic               pop;
    logic [SUM_W-1:0]   drop_sum;
    logic [CNT_W-1:0]   drop_nxt;

    // Per-channel event detect, packing offsets and entry payloads.
    always_comb begin
        n_ev  = '0;
        n_ret = '0;
        for (int i = 0; i < NRET; i++) begin
            ev[i]          = en & (in_valid[i] | in_rdv[i] | in_pcv[i]);
            off[i]         = n_ev;
            n_ev           = n_ev + NCNT_W'(ev[i]);
            n_ret          = n_ret + NCNT_W'(en & in_valid[i]);
            ent[i].valid_i = in_valid[i];
            ent[i].pc      = in_pc[i*XLEN +: XLEN];
            ent[i].inst    = in_inst[i*32 +: 32];
            ent[i].rdv     = in_rdv[i];
            ent[i].rd      = in_rd[i*5 +: 5];
            ent[i].rd_data = in_rd_data[i*XLEN +: XLEN];
            ent[i].pcv     = in_pcv[i];
            ent[i].pc_x    = in_pc_x[i*XLEN +: XLEN];
            ent[i].seq     = seq + SEQ_W'(off[i]);
        end
    end

    // All-or-nothing space check against start-of-cycle occupancy; pops never credit.
    always_comb begin
        free     = LVL_W'(DEPTH) - level;
        drop     = !flush && (LVL_W'(n_ev) > free);
        accept   = !flush && !drop;
        n_push   = accept ? n_ev : '0;
        pop      = out_valid && out_ready && !flush;
        drop_sum = {1'b0, drop_cnt} + SUM_W'(n_ev);
        drop_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seq        <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            retire_cnt <= '0;
        end else begin
            retire_cnt <= retire_cnt + CNT_W'(n_ret);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                    drop_cnt <= drop_nxt;
                end else if (n_ev != '0) begin
                    for (int i = 0; i < NRET; i++) begin
                        if (ev[i]) begin
                            mem[wr_ptr + PTR_W'(off[i])] <= ent[i];
                        end
                    end
                    wr_ptr <= wr_ptr + PTR_W'(n_ev);
                    seq    <= seq + SEQ_W'(n_ev);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                level <= level + LVL_W'(n_push) - LVL_W'(pop);
            end
        end
    end

    // Head entry is presented directly from storage.
    assign head        = mem[rd_ptr];
    assign out_valid   = (level != '0);
    assign out_valid_i = head.valid_i;
    assign out_pc      = head.pc;
    assign out_inst    = head.inst;
    assign out_rdv     = head.rdv;
    assign out_rd      = head.rd;
    assign out_rd_data = head.rd_data;
    assign out_pcv     = head.pcv;
    assign out_pc_x    = head.pc_x;
    assign out_seq     = head.seq;

endmodule
